// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART transmitter paced by a 16x oversampling tick.
// Frame = start bit, DBIT data bits, optional parity bit, stop period of SB_TICK ticks.
// tx, tx_busy and tx_done_tick are all registered; their next values are derived
// from the next state so that tx falls on the edge that accepts tx_start.
module uart_tx #(
    parameter int unsigned DBIT    = 8,   // data bits per frame (5..9)
    parameter int unsigned SB_TICK = 16,  // stop period in ticks: 16, 24 or 32
    parameter int unsigned PARITY  = 0    // 0 = none, 1 = odd, 2 = even
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [5:0]    S_LAST_BIT  = 6'd15;
    localparam logic [5:0]    S_LAST_STOP = 6'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
    localparam logic          PAR_EN      = (PARITY != 0);
    localparam logic          PAR_ODD     = (PARITY == 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [5:0]      s_q, s_d;      // tick counter within the current bit
    logic [NW-1:0]   n_q, n_d;      // data bit index
    logic [DBIT-1:0] b_q, b_d;      // shift register, LSB goes out first
    logic            p_q, p_d;      // parity bit computed at acceptance
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Next-state logic: counters advance only on s_tick; idle ignores s_tick.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_d     = p_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_start) begin
                    b_d     = din;
                    s_d     = 6'd0;
                    n_d     = '0;
                    p_d     = PAR_ODD ? ~^din : ^din;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (s_q == S_LAST_BIT) begin
                        s_d     = 6'd0;
                        state_d = StData;
                    end else begin
                        s_d = s_q + 6'd1;
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (s_q == S_LAST_BIT) begin
                        s_d = 6'd0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = PAR_EN ? StParity : StStop;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 6'd1;
                    end
                end
            end
            StParity: begin
                if (s_tick) begin
                    if (s_q == S_LAST_BIT) begin
                        s_d     = 6'd0;
                        state_d = StStop;
                    end else begin
                        s_d = s_q + 6'd1;
                    end
                end
            end
            StStop: begin
                if (s_tick) begin
                    if (s_q == S_LAST_STOP) begin
                        s_d     = 6'd0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        s_d = s_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next values follow the next state so the line level changes on the
    // same edge as the state transition.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != StIdle);
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = b_d[0];
            StParity: tx_d = p_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // State and output registers; reset aborts any frame with the line idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            s_q     <= 6'd0;
            n_q     <= '0;
            b_q     <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Four instances cover 8N1, odd parity,
// even parity and a two-stop-bit configuration; a monitor decodes the selected line.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] div = 2'd0;
    logic       s_tick;
    logic       tick_edge = 1'b0;

    logic [3:0] start_v;
    logic [7:0] din_v [4];
    logic [3:0] tx_w, busy_w, done_w;

    always #5 clk = ~clk;

    // One s_tick every 4th clk.
    always @(posedge clk) div <= div + 2'd1;
    assign s_tick = (div == 2'd3);

    // Remember whether the edge just taken carried a tick.
    always @(posedge clk) tick_edge <= s_tick;

    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_8n1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[0]), .din(din_v[0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_odd (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[1]), .din(din_v[1]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_even (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[2]), .din(din_v[2]),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]));
    uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u_sb32 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[3]), .din(din_v[3]),
        .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]));

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       par_en;
        logic       par;
        int         stop_len;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   sel = 0;
    int   spurious_done = 0;
    int   frames_done = 0;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic push_exp(input int ch, input logic [7:0] d, input logic pe, input logic pb,
                            input int sl);
        exp_t e;
        e.ch = ch;
        e.data = d;
        e.par_en = pe;
        e.par = pb;
        e.stop_len = sl;
        sb_q.push_back(e);
    endtask

    // Monitor state.
    logic       in_frame = 1'b0;
    int         cnt = 0;
    int         frame_len = 0;
    int         stop_at = 0;
    logic [7:0] got_data = 8'h00;
    logic       got_par = 1'b0;
    logic       start_ok = 1'b1;
    logic       stop_ok = 1'b1;
    logic       busy_ok = 1'b1;
    exp_t       cur;

    // Monitor: detect start bit, count ticks, sample bit centres, compare at frame end.
    always @(negedge clk) begin
        if (reset) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (done_w[sel]) spurious_done++;
            if (!tx_w[sel]) begin
                check("frame_expected", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    cur = sb_q.pop_front();
                end else begin
                    cur.ch = sel;
                    cur.data = 8'h00;
                    cur.par_en = 1'b0;
                    cur.par = 1'b0;
                    cur.stop_len = 16;
                end
                check("frame_chan", sel, cur.ch);
                in_frame  = 1'b1;
                cnt       = 0;
                start_ok  = 1'b1;
                stop_ok   = 1'b1;
                busy_ok   = 1'b1;
                got_data  = 8'h00;
                got_par   = 1'b0;
                stop_at   = 16 * (9 + int'(cur.par_en));
                frame_len = stop_at + cur.stop_len;
            end
        end else begin
            if (tick_edge) begin
                cnt++;
                if (cnt == 8 && tx_w[sel]) start_ok = 1'b0;
                if (cnt >= 24 && cnt < 144 && (cnt % 16) == 8) got_data[(cnt - 24) / 16] = tx_w[sel];
                if (cnt == 152) got_par = tx_w[sel];
                if (cnt >= stop_at && cnt < frame_len && !tx_w[sel]) stop_ok = 1'b0;
            end
            if (cnt < frame_len && !busy_w[sel]) busy_ok = 1'b0;
            if (cnt == frame_len) begin
                check("done_at_frame_len", int'(done_w[sel]), 1);
                check("busy_clear_at_end", int'(busy_w[sel]), 0);
                check("data", int'(got_data), int'(cur.data));
                if (cur.par_en) check("parity_bit", int'(got_par), int'(cur.par));
                check("start_bit", int'(start_ok), 1);
                check("stop_level", int'(stop_ok), 1);
                check("busy_held", int'(busy_ok), 1);
                frames_done++;
                in_frame = 1'b0;
            end else if (done_w[sel]) begin
                spurious_done++;
            end
        end
    end

    task automatic send(input int ch, input logic [7:0] d);
        sel = ch;
        start_v[ch] = 1'b1;
        din_v[ch] = d;
        @(negedge clk);
        start_v[ch] = 1'b0;
        din_v[ch] = ~d;
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(sb_q.size() == 0 && !in_frame && !busy_w[sel]) && k < limit);
        check("idle_reached", int'(sb_q.size() == 0 && !in_frame && !busy_w[sel]), 1);
    endtask

    initial begin
        int k;
        int dones;
        reset = 1'b1;
        start_v = 4'hF;
        for (int i = 0; i < 4; i++) din_v[i] = 8'hA5;

        // Reset held with tx_start high on every channel.
        repeat (4) begin
            @(negedge clk);
            check("rst_tx", int'(tx_w), 4'hF);
            check("rst_busy", int'(busy_w), 0);
            check("rst_done", int'(done_w), 0);
        end

        // Release reset with tx_start still high on channel 0: 8N1 0xA5.
        sel = 0;
        push_exp(0, 8'hA5, 1'b0, 1'b0, 16);
        start_v = 4'b0001;
        reset = 1'b0;
        @(negedge clk);
        start_v = 4'b0000;
        check("first_start_after_reset", int'(tx_w[0]), 0);
        check("first_busy_after_reset", int'(busy_w[0]), 1);
        check("others_idle", int'(tx_w[3:1]), 3'b111);
        wait_idle(2000);

        // Odd parity: 0xA5 -> 1, 0x07 -> 0. Even parity: 0x07 -> 1, 0xA5 -> 0.
        push_exp(1, 8'hA5, 1'b1, 1'b1, 16);
        send(1, 8'hA5);
        wait_idle(2000);
        push_exp(1, 8'h07, 1'b1, 1'b0, 16);
        send(1, 8'h07);
        wait_idle(2000);
        push_exp(2, 8'h07, 1'b1, 1'b1, 16);
        send(2, 8'h07);
        wait_idle(2000);
        push_exp(2, 8'hA5, 1'b1, 1'b0, 16);
        send(2, 8'hA5);
        wait_idle(2000);

        // tx_start mid-frame is ignored.
        push_exp(0, 8'h55, 1'b0, 1'b0, 16);
        send(0, 8'h55);
        repeat (200) @(negedge clk);
        din_v[0] = 8'h3C;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_idle(2000);
        repeat (100) @(negedge clk);

        // Back-to-back: start 0x12 in the cycle done is high for 0xFF.
        push_exp(0, 8'hFF, 1'b0, 1'b0, 16);
        push_exp(0, 8'h12, 1'b0, 1'b0, 16);
        send(0, 8'hFF);
        k = 0;
        while (!done_w[0] && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("b2b_done_seen", int'(done_w[0]), 1);
        start_v[0] = 1'b1;
        din_v[0] = 8'h12;
        @(negedge clk);
        start_v[0] = 1'b0;
        din_v[0] = 8'h00;
        check("b2b_zero_gap_tx", int'(tx_w[0]), 0);
        check("b2b_zero_gap_busy", int'(busy_w[0]), 1);
        wait_idle(2000);

        // Two stop bits.
        push_exp(3, 8'h3C, 1'b0, 1'b0, 32);
        send(3, 8'h3C);
        wait_idle(2000);

        // Reset in the middle of data bit 3 of 0xF0 (bit 3 is 0).
        push_exp(3, 8'hF0, 1'b0, 1'b0, 32);
        send(3, 8'hF0);
        k = 0;
        while (!(in_frame && cnt >= 72) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("pre_reset_tx_low", int'(tx_w[3]), 0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_tx", int'(tx_w[3]), 1);
        check("async_reset_busy", int'(busy_w[3]), 0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_w[3]) dones++;
        end
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_w[3]) dones++;
        end
        check("no_done_after_abort", dones, 0);
        push_exp(3, 8'hA5, 1'b0, 1'b0, 32);
        send(3, 8'hA5);
        wait_idle(2000);

        repeat (50) @(negedge clk);
        check("spurious_done", spurious_done, 0);
        check("frames_completed", frames_done, 10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
